// File: rtl/clock_time_core.sv
// Time-of-day core: DIV prescaler to a 1 Hz tick, BCD HH:MM:SS with set mode, registered 7-seg outputs.
// Build option: define TWELVE_HOUR_EN for a 12-hour display with the PM flag on DOT[0].
module clock_time_core #(
   parameter int DIV = 100_000_000
) (
   input  logic       CP_100MHz,
   input  logic       nCLR,
   input  logic       MODE_P,
   input  logic       INC_P,
   output logic [6:0] SEG7,
   output logic [6:0] SEG6,
   output logic [6:0] SEG5,
   output logic [6:0] SEG4,
   output logic [6:0] SEG3,
   output logic [6:0] SEG2,
   output logic [6:0] SEG1,
   output logic [6:0] SEG0,
   output logic [7:0] DOT,
   output logic       TICK
);
   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] P_HALF = PW'(DIV / 2);
   localparam logic [6:0] C_ZERO  = 7'b100_0000;
   localparam logic [6:0] C_DASH  = 7'b011_1111;
   localparam logic [6:0] C_BLANK = 7'b111_1111;
`ifdef TWELVE_HOUR_EN
   localparam logic [6:0] RST_H1 = 7'b111_1001;
   localparam logic [6:0] RST_H0 = 7'b010_0100;
`else
   localparam logic [6:0] RST_H1 = C_ZERO;
   localparam logic [6:0] RST_H0 = C_ZERO;
`endif

   typedef enum logic [1:0] {S_RUN, S_SET_HR, S_SET_MIN, S_SET_SEC} state_t;

   state_t           r_state, w_state;
   logic [PW-1:0]    r_presc;
   logic [7:0]       r_hr, r_min, r_sec;
   logic [7:0]       w_hr, w_min, w_sec;
   logic [7:0][6:0]  r_seg, w_seg;
   logic [7:0]       r_dot, w_dot;
   logic             r_tick;
   logic             w_wrap, w_blank;
   logic [6:0]       w_h1, w_h0;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0: seg_code = 7'b100_0000;
         4'd1: seg_code = 7'b111_1001;
         4'd2: seg_code = 7'b010_0100;
         4'd3: seg_code = 7'b011_0000;
         4'd4: seg_code = 7'b001_1001;
         4'd5: seg_code = 7'b001_0010;
         4'd6: seg_code = 7'b000_0010;
         4'd7: seg_code = 7'b111_1000;
         4'd8: seg_code = 7'b000_0000;
         4'd9: seg_code = 7'b001_0000;
         default: seg_code = C_BLANK;
      endcase
   endfunction

   // BCD increment modulo 60 and modulo 24
   function automatic logic [7:0] inc59(input logic [7:0] v);
      if (v[3:0] != 4'd9)      inc59 = {v[7:4], v[3:0] + 4'd1};
      else if (v[7:4] != 4'd5) inc59 = {v[7:4] + 4'd1, 4'd0};
      else                     inc59 = 8'h00;
   endfunction

   function automatic logic [7:0] inc23(input logic [7:0] v);
      if (v == 8'h23)          inc23 = 8'h00;
      else if (v[3:0] == 4'd9) inc23 = {v[7:4] + 4'd1, 4'd0};
      else                     inc23 = {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign w_wrap = (r_presc == P_LAST);

   always_comb begin
      w_state = r_state;
      w_hr    = r_hr;
      w_min   = r_min;
      w_sec   = r_sec;
      if (MODE_P) begin
         case (r_state)
            S_RUN:     w_state = S_SET_HR;
            S_SET_HR:  w_state = S_SET_MIN;
            S_SET_MIN: w_state = S_SET_SEC;
            default:   w_state = S_RUN;
         endcase
      end
      // A wrap in the RUN cycle that also carries MODE_P still counts
      case (r_state)
         S_RUN: if (w_wrap) begin
            w_sec = inc59(r_sec);
            if (r_sec == 8'h59) begin
               w_min = inc59(r_min);
               if (r_min == 8'h59) w_hr = inc23(r_hr);
            end
         end
         S_SET_HR:  if (INC_P && !MODE_P) w_hr  = inc23(r_hr);
         S_SET_MIN: if (INC_P && !MODE_P) w_min = inc59(r_min);
         default:   if (INC_P && !MODE_P) w_sec = 8'h00;
      endcase
   end

`ifdef TWELVE_HOUR_EN
   logic [4:0] w_hbin;
   logic [3:0] w_hdisp, w_hlo;
   always_comb begin
      w_hbin = 5'(r_hr[7:4]) * 5'd10 + 5'(r_hr[3:0]);
      if (w_hbin == 5'd0)       w_hdisp = 4'd12;
      else if (w_hbin > 5'd12)  w_hdisp = 4'(w_hbin - 5'd12);
      else                      w_hdisp = w_hbin[3:0];
      w_hlo = (w_hdisp >= 4'd10) ? w_hdisp - 4'd10 : w_hdisp;
      w_h1  = (w_hdisp >= 4'd10) ? seg_code(4'd1) : C_BLANK;
      w_h0  = seg_code(w_hlo);
      w_dot = {7'd0, (w_hbin >= 5'd12)};
   end
`else
   always_comb begin
      w_h1  = seg_code(r_hr[7:4]);
      w_h0  = seg_code(r_hr[3:0]);
      w_dot = 8'h00;
   end
`endif

   always_comb begin
      w_blank  = (r_state != S_RUN) && (r_presc >= P_HALF);
      w_seg[7] = (w_blank && r_state == S_SET_HR)  ? C_BLANK : w_h1;
      w_seg[6] = (w_blank && r_state == S_SET_HR)  ? C_BLANK : w_h0;
      w_seg[5] = C_DASH;
      w_seg[4] = (w_blank && r_state == S_SET_MIN) ? C_BLANK : seg_code(r_min[7:4]);
      w_seg[3] = (w_blank && r_state == S_SET_MIN) ? C_BLANK : seg_code(r_min[3:0]);
      w_seg[2] = C_DASH;
      w_seg[1] = (w_blank && r_state == S_SET_SEC) ? C_BLANK : seg_code(r_sec[7:4]);
      w_seg[0] = (w_blank && r_state == S_SET_SEC) ? C_BLANK : seg_code(r_sec[3:0]);
   end

   always_ff @(posedge CP_100MHz or negedge nCLR) begin
      if (!nCLR) begin
         r_state <= S_RUN;
         r_presc <= '0;
         r_hr    <= 8'h00;
         r_min   <= 8'h00;
         r_sec   <= 8'h00;
         r_tick  <= 1'b0;
         r_dot   <= 8'h00;
         r_seg   <= {RST_H1, RST_H0, C_DASH, C_ZERO, C_ZERO, C_DASH, C_ZERO, C_ZERO};
      end else begin
         r_state <= w_state;
         // Leaving SET_SEC restarts the second so counting resumes a full second later
         if (w_wrap || (r_state == S_SET_SEC && MODE_P)) r_presc <= '0;
         else                                           r_presc <= r_presc + 1'b1;
         r_hr    <= w_hr;
         r_min   <= w_min;
         r_sec   <= w_sec;
         r_tick  <= w_wrap;
         r_dot   <= w_dot;
         r_seg   <= w_seg;
      end
   end

   assign SEG7 = r_seg[7];
   assign SEG6 = r_seg[6];
   assign SEG5 = r_seg[5];
   assign SEG4 = r_seg[4];
   assign SEG3 = r_seg[3];
   assign SEG2 = r_seg[2];
   assign SEG1 = r_seg[1];
   assign SEG0 = r_seg[0];
   assign DOT  = r_dot;
   assign TICK = r_tick;

endmodule
